// File: rtl/decode_stage_p.sv
// MIPS instruction-decode stage: register file with optional WB bypass, load-use
// hazard detection, branch/jump resolution in ID and a RUN/DRAIN/HALTED halt sequencer.
module decode_stage_p #(
  parameter int NB_DATA      = 32,
  parameter int NB_ADDR      = 5,
  parameter int DRAIN_CYCLES = 3,
  parameter bit WB_BYPASS    = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_pc4,
  input  logic [31:0]        i_instruction,
  input  logic               i_flush,
  input  logic               i_debug_halt,
  input  logic               i_wb_write,
  input  logic [NB_ADDR-1:0] i_wb_addr,
  input  logic [NB_DATA-1:0] i_wb_data,
  input  logic               i_ex_mem_read,
  input  logic [NB_ADDR-1:0] i_ex_rt,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic [NB_DATA-1:0] o_dbg_data,
  output logic               o_stall,
  output logic               o_jump,
  output logic [NB_DATA-1:0] o_jump_addr,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_RA,
  output logic [NB_DATA-1:0] o_RB,
  output logic [NB_DATA-1:0] o_imm,
  output logic [NB_ADDR-1:0] o_rs,
  output logic [NB_ADDR-1:0] o_rt,
  output logic [NB_ADDR-1:0] o_rd,
  output logic [5:0]         o_opcode,
  output logic [5:0]         o_funct,
  output logic [4:0]         o_shamt,
  output logic               o_wb_write,
  output logic               o_mem_to_reg,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_alu_src,
  output logic               o_reg_dst,
  output logic [1:0]         o_alu_op,
  output logic [1:0]         o_mem_size,
  output logic               o_mem_unsigned,
  output logic               o_halted
);
  localparam int NREGS = 2 ** NB_ADDR;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic               valid;
    logic [NB_DATA-1:0] ra;
    logic [NB_DATA-1:0] rb;
    logic [NB_DATA-1:0] imm;
    logic [NB_ADDR-1:0] rs;
    logic [NB_ADDR-1:0] rt;
    logic [NB_ADDR-1:0] rd;
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [4:0]         shamt;
    logic               wb_write;
    logic               mem_to_reg;
    logic               mem_read;
    logic               mem_write;
    logic               alu_src;
    logic               reg_dst;
    logic [1:0]         alu_op;
    logic [1:0]         mem_size;
    logic               mem_unsigned;
  } idex_t;

  logic [NB_DATA-1:0] regs [NREGS];
  idex_t              idex_reg, idex_next;
  state_t             state_reg;
  logic [3:0]         cnt_reg;
  logic               halted_reg;

  logic [5:0]         opcode, funct;
  logic [NB_ADDR-1:0] f_rs, f_rt, f_rd;
  logic [NB_DATA-1:0] imm, rd_a, rd_b;
  logic is_rtype, is_jr, is_jalr, is_j, is_jal, is_beq, is_bne;
  logic is_immop, is_load, is_store, is_halt, is_nop;
  logic reads_rs, reads_rt, hazard, stall;

  assign opcode   = i_instruction[31:26];
  assign funct    = i_instruction[5:0];
  assign f_rs     = NB_ADDR'(i_instruction[25:21]);
  assign f_rt     = NB_ADDR'(i_instruction[20:16]);
  assign f_rd     = NB_ADDR'(i_instruction[15:11]);
  assign imm      = {{(NB_DATA-16){i_instruction[15]}}, i_instruction[15:0]};
  assign is_rtype = (opcode == 6'd0);
  assign is_jr    = is_rtype && (funct == 6'h08);
  assign is_jalr  = is_rtype && (funct == 6'h09);
  assign is_j     = (opcode == 6'd2);
  assign is_jal   = (opcode == 6'd3);
  assign is_beq   = (opcode == 6'd4);
  assign is_bne   = (opcode == 6'd5);
  assign is_immop = (opcode[5:3] == 3'b001);
  assign is_load  = opcode[5] && !opcode[3];
  assign is_store = opcode[5] && opcode[3];
  assign is_halt  = (i_instruction == 32'hFFFF_FFFF);
  assign is_nop   = (i_instruction == 32'd0);

  // Register file; address 0 is never written so it stays at its reset value of 0.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (i_wb_write && !i_debug_halt && i_wb_addr != '0) begin
      regs[i_wb_addr] <= i_wb_data;
    end
  end

  always_comb begin
    rd_a = regs[f_rs];
    rd_b = regs[f_rt];
    if (WB_BYPASS && i_wb_write && f_rs != '0 && f_rs == i_wb_addr) rd_a = i_wb_data;
    if (WB_BYPASS && i_wb_write && f_rt != '0 && f_rt == i_wb_addr) rd_b = i_wb_data;
  end

  assign o_dbg_data = regs[i_dbg_addr];

  assign reads_rs = !(is_j || is_jal);
  assign reads_rt = is_rtype || is_beq || is_bne || is_store;
  assign hazard   = i_ex_mem_read && (i_ex_rt != '0) &&
                    ((reads_rs && i_ex_rt == f_rs) || (reads_rt && i_ex_rt == f_rt));

  // Debug freeze and drain/halt both hold the front end; flush overrides a hazard stall.
  always_comb begin
    if (i_debug_halt || state_reg != RUN) stall = 1'b1;
    else                                  stall = i_valid && !i_flush && hazard;
  end
  assign o_stall = stall;

  always_comb begin
    o_jump      = 1'b0;
    o_jump_addr = '0;
    if (i_valid && !stall && !i_flush) begin
      if ((is_beq && rd_a == rd_b) || (is_bne && rd_a != rd_b)) begin
        o_jump      = 1'b1;
        o_jump_addr = i_pc4 + (imm << 2);
      end else if (is_j || is_jal) begin
        o_jump      = 1'b1;
        o_jump_addr = {i_pc4[NB_DATA-1:28], i_instruction[25:0], 2'b00};
      end else if (is_jr || is_jalr) begin
        o_jump      = 1'b1;
        o_jump_addr = rd_a;
      end
    end
  end

  always_comb begin
    idex_next        = '0;
    idex_next.valid  = 1'b1;
    idex_next.ra     = rd_a;
    idex_next.rb     = rd_b;
    idex_next.imm    = imm;
    idex_next.rs     = f_rs;
    idex_next.rt     = f_rt;
    idex_next.rd     = f_rd;
    idex_next.opcode = opcode;
    idex_next.funct  = funct;
    idex_next.shamt  = i_instruction[10:6];
    // mem_to_reg=1 selects the ALU result for write-back, 0 selects load data.
    if (is_rtype) begin
      idex_next.reg_dst    = 1'b1;
      idex_next.alu_op     = 2'b10;
      idex_next.wb_write   = !is_jr;
      idex_next.mem_to_reg = 1'b1;
      if (is_jalr) begin
        idex_next.ra     = i_pc4;
        idex_next.rb     = NB_DATA'(4);
        idex_next.rs     = '0;
        idex_next.alu_op = 2'b00;
      end
    end else if (is_immop) begin
      idex_next.alu_src    = 1'b1;
      idex_next.alu_op     = 2'b11;
      idex_next.wb_write   = 1'b1;
      idex_next.mem_to_reg = 1'b1;
    end else if (is_load || is_store) begin
      idex_next.alu_src      = 1'b1;
      idex_next.mem_read     = is_load;
      idex_next.mem_write    = is_store;
      idex_next.wb_write     = is_load;
      idex_next.mem_size     = opcode[1:0];
      idex_next.mem_unsigned = opcode[2];
    end else if (is_jal) begin
      idex_next.ra         = i_pc4;
      idex_next.rb         = NB_DATA'(4);
      idex_next.rs         = '0;
      idex_next.rt         = NB_ADDR'(31);
      idex_next.wb_write   = 1'b1;
      idex_next.mem_to_reg = 1'b1;
    end else begin
      idex_next.alu_op = 2'b01;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      idex_reg   <= '0;
      state_reg  <= RUN;
      cnt_reg    <= '0;
      halted_reg <= 1'b0;
    end else if (!i_debug_halt) begin
      if (i_flush) begin
        idex_reg <= '0;
      end else begin
        case (state_reg)
          RUN: begin
            if (i_valid && hazard) begin
              idex_reg <= '0;
            end else if (i_valid && is_halt) begin
              idex_reg  <= '0;
              state_reg <= DRAIN;
              cnt_reg   <= 4'(DRAIN_CYCLES - 1);
            end else if (i_valid && !is_nop) begin
              idex_reg <= idex_next;
            end else begin
              idex_reg <= '0;
            end
          end
          DRAIN: begin
            idex_reg <= '0;
            if (cnt_reg == '0) begin
              state_reg  <= HALTED;
              halted_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg - 4'd1;
            end
          end
          HALTED:  idex_reg <= '0;
          default: state_reg <= RUN;
        endcase
      end
    end
  end

  assign o_valid        = idex_reg.valid;
  assign o_RA           = idex_reg.ra;
  assign o_RB           = idex_reg.rb;
  assign o_imm          = idex_reg.imm;
  assign o_rs           = idex_reg.rs;
  assign o_rt           = idex_reg.rt;
  assign o_rd           = idex_reg.rd;
  assign o_opcode       = idex_reg.opcode;
  assign o_funct        = idex_reg.funct;
  assign o_shamt        = idex_reg.shamt;
  assign o_wb_write     = idex_reg.wb_write;
  assign o_mem_to_reg   = idex_reg.mem_to_reg;
  assign o_mem_read     = idex_reg.mem_read;
  assign o_mem_write    = idex_reg.mem_write;
  assign o_alu_src      = idex_reg.alu_src;
  assign o_reg_dst      = idex_reg.reg_dst;
  assign o_alu_op       = idex_reg.alu_op;
  assign o_mem_size     = idex_reg.mem_size;
  assign o_mem_unsigned = idex_reg.mem_unsigned;
  assign o_halted       = halted_reg;

endmodule

// File: tb/tb_decode_stage_p.sv
// Directed testbench for decode_stage_p: one task per feature, inline checks.
module tb_decode_stage_p;
  logic        clk = 1'b0;
  logic        reset, valid, flush, debug_halt, wb_write, ex_mem_read;
  logic [31:0] pc4, instruction, wb_data;
  logic [4:0]  wb_addr, ex_rt, dbg_addr;
  logic [31:0] dbg_data, jump_addr, ra, rb, imm;
  logic        stall, jump, o_valid, o_wb_write, mem_to_reg, mem_read, mem_write;
  logic        alu_src, reg_dst, mem_unsigned, halted;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  opcode, funct;
  logic [1:0]  alu_op, mem_size;
  int errors = 0;
  int checks = 0;

  localparam logic [5:0] ADD = 6'h20;

  decode_stage_p #(.NB_DATA(32), .NB_ADDR(5), .DRAIN_CYCLES(3), .WB_BYPASS(1'b1)) dut (
    .i_clk(clk), .i_reset(reset), .i_valid(valid), .i_pc4(pc4), .i_instruction(instruction),
    .i_flush(flush), .i_debug_halt(debug_halt), .i_wb_write(wb_write), .i_wb_addr(wb_addr),
    .i_wb_data(wb_data), .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt), .i_dbg_addr(dbg_addr),
    .o_dbg_data(dbg_data), .o_stall(stall), .o_jump(jump), .o_jump_addr(jump_addr),
    .o_valid(o_valid), .o_RA(ra), .o_RB(rb), .o_imm(imm), .o_rs(rs), .o_rt(rt), .o_rd(rd),
    .o_opcode(opcode), .o_funct(funct), .o_shamt(shamt), .o_wb_write(o_wb_write),
    .o_mem_to_reg(mem_to_reg), .o_mem_read(mem_read), .o_mem_write(mem_write),
    .o_alu_src(alu_src), .o_reg_dst(reg_dst), .o_alu_op(alu_op), .o_mem_size(mem_size),
    .o_mem_unsigned(mem_unsigned), .o_halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [5:0] fn);
    return {6'd0, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; valid = 1'b0; flush = 1'b0; debug_halt = 1'b0; wb_write = 1'b0;
    ex_mem_read = 1'b0; pc4 = '0; instruction = '0; wb_data = '0; wb_addr = '0;
    ex_rt = '0; dbg_addr = 5'd5;
    tick; tick;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    checks++; if (ra !== 32'd0) begin errors++; $display("FAIL reset_ra: got %h expected 0", ra); end
    checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL reset_reg5: got %h expected 0", dbg_data); end
    reset = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    $display("test_reset done: errors=%0d", errors);
  endtask

  task automatic test_regfile_add;
    wb_write = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
    tick;
    wb_write = 1'b0; dbg_addr = 5'd5; #1;
    checks++; if (dbg_data !== 32'h1234) begin errors++; $display("FAIL wb_r5: got %h expected 1234", dbg_data); end
    valid = 1'b1; instruction = rtype(5'd5, 5'd0, 5'd6, ADD);
    tick;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b expected 1", o_valid); end
    checks++; if (ra !== 32'h1234) begin errors++; $display("FAIL add_ra: got %h expected 1234", ra); end
    checks++; if (reg_dst !== 1'b1) begin errors++; $display("FAIL add_reg_dst: got %b expected 1", reg_dst); end
    checks++; if (alu_op !== 2'b10) begin errors++; $display("FAIL add_alu_op: got %b expected 10", alu_op); end
    checks++; if (o_wb_write !== 1'b1) begin errors++; $display("FAIL add_wb_write: got %b expected 1", o_wb_write); end
    checks++; if (rd !== 5'd6) begin errors++; $display("FAIL add_rd: got %0d expected 6", rd); end
    $display("test_regfile_add done: errors=%0d", errors);
  endtask

  task automatic test_bypass;
    wb_write = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD;
    instruction = rtype(5'd3, 5'd0, 5'd4, ADD);
    tick;
    checks++; if (ra !== 32'hDEAD) begin errors++; $display("FAIL bypass_ra: got %h expected dead", ra); end
    wb_addr = 5'd0; wb_data = 32'h5555; instruction = rtype(5'd0, 5'd0, 5'd4, ADD);
    tick;
    checks++; if (ra !== 32'd0) begin errors++; $display("FAIL bypass_r0: got %h expected 0", ra); end
    wb_write = 1'b0; dbg_addr = 5'd0; #1;
    checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL r0_write: got %h expected 0", dbg_data); end
    $display("test_bypass done: errors=%0d", errors);
  endtask

  task automatic test_hazard;
    ex_mem_read = 1'b1; ex_rt = 5'd3; instruction = rtype(5'd3, 5'd2, 5'd4, ADD); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hz_rs_stall: got %b expected 1", stall); end
    tick;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL hz_bubble: got %b expected 0", o_valid); end
    ex_mem_read = 1'b0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hz_release: got %b expected 0", stall); end
    tick;
    checks++; if (o_valid !== 1'b1 || ra !== 32'hDEAD) begin errors++; $display("FAIL hz_issue: got valid=%b ra=%h expected valid=1 ra=dead", o_valid, ra); end
    ex_mem_read = 1'b1; ex_rt = 5'd2; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hz_rt_stall: got %b expected 1", stall); end
    instruction = itype(6'b001000, 5'd1, 5'd2, 16'h0010); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hz_imm_rt: got %b expected 0", stall); end
    tick;
    checks++; if (alu_src !== 1'b1 || alu_op !== 2'b11 || imm !== 32'h10) begin errors++; $display("FAIL addi_decode: got src=%b op=%b imm=%h expected src=1 op=11 imm=10", alu_src, alu_op, imm); end
    ex_rt = 5'd0; instruction = rtype(5'd0, 5'd0, 5'd4, ADD); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hz_r0: got %b expected 0", stall); end
    ex_rt = 5'd3; instruction = rtype(5'd3, 5'd2, 5'd4, ADD); flush = 1'b1; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_hz_stall: got %b expected 0", stall); end
    tick;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_bubble: got %b expected 0", o_valid); end
    flush = 1'b0; ex_mem_read = 1'b0;
    $display("test_hazard done: errors=%0d", errors);
  endtask

  task automatic test_branch;
    valid = 1'b0; wb_write = 1'b1; wb_addr = 5'd1; wb_data = 32'd7;
    tick;
    wb_addr = 5'd2;
    tick;
    wb_write = 1'b0; valid = 1'b1; pc4 = 32'h100;
    instruction = itype(6'd4, 5'd1, 5'd2, 16'hFFFF); #1;
    checks++; if (jump !== 1'b1 || jump_addr !== 32'hFC) begin errors++; $display("FAIL beq_taken: got jump=%b addr=%h expected jump=1 addr=fc", jump, jump_addr); end
    ex_mem_read = 1'b1; ex_rt = 5'd1; #1;
    checks++; if (jump !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL beq_stalled: got jump=%b stall=%b expected jump=0 stall=1", jump, stall); end
    ex_mem_read = 1'b0; instruction = itype(6'd5, 5'd1, 5'd2, 16'hFFFF); #1;
    checks++; if (jump !== 1'b0) begin errors++; $display("FAIL bne_equal: got %b expected 0", jump); end
    tick;
    checks++; if (alu_op !== 2'b01 || o_wb_write !== 1'b0 || o_valid !== 1'b1) begin errors++; $display("FAIL bne_decode: got op=%b wb=%b valid=%b expected op=01 wb=0 valid=1", alu_op, o_wb_write, o_valid); end
    instruction = rtype(5'd1, 5'd0, 5'd0, 6'h08); #1;
    checks++; if (jump !== 1'b1 || jump_addr !== 32'd7) begin errors++; $display("FAIL jr_target: got jump=%b addr=%h expected jump=1 addr=7", jump, jump_addr); end
    $display("test_branch done: errors=%0d", errors);
  endtask

  task automatic test_jal;
    pc4 = 32'h1000_0008; instruction = {6'd3, 26'h40}; #1;
    checks++; if (jump !== 1'b1 || jump_addr !== 32'h1000_0100) begin errors++; $display("FAIL jal_target: got jump=%b addr=%h expected jump=1 addr=10000100", jump, jump_addr); end
    tick;
    checks++; if (ra !== 32'h1000_0008 || rb !== 32'd4) begin errors++; $display("FAIL jal_operands: got ra=%h rb=%h expected ra=10000008 rb=4", ra, rb); end
    checks++; if (rt !== 5'd31 || rs !== 5'd0 || o_wb_write !== 1'b1) begin errors++; $display("FAIL jal_regs: got rt=%0d rs=%0d wb=%b expected rt=31 rs=0 wb=1", rt, rs, o_wb_write); end
    $display("test_jal done: errors=%0d", errors);
  endtask

  task automatic test_mem;
    instruction = itype(6'b100011, 5'd1, 5'd5, 16'd4);
    tick;
    checks++; if (mem_read !== 1'b1 || mem_size !== 2'b11 || mem_unsigned !== 1'b0 || mem_to_reg !== 1'b0 || o_wb_write !== 1'b1) begin errors++; $display("FAIL lw_decode: got rd=%b size=%b uns=%b m2r=%b wb=%b expected 1 11 0 0 1", mem_read, mem_size, mem_unsigned, mem_to_reg, o_wb_write); end
    instruction = itype(6'b100100, 5'd1, 5'd5, 16'd4);
    tick;
    checks++; if (mem_size !== 2'b00 || mem_unsigned !== 1'b1) begin errors++; $display("FAIL lbu_decode: got size=%b uns=%b expected 00 1", mem_size, mem_unsigned); end
    instruction = itype(6'b101011, 5'd1, 5'd5, 16'd4);
    tick;
    checks++; if (mem_write !== 1'b1 || o_wb_write !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL sw_decode: got wr=%b wb=%b rd=%b expected 1 0 0", mem_write, o_wb_write, mem_read); end
    instruction = 32'd0;
    tick;
    checks++; if (o_valid !== 1'b0 || alu_op !== 2'b00) begin errors++; $display("FAIL nop_bubble: got valid=%b op=%b expected 0 00", o_valid, alu_op); end
    $display("test_mem done: errors=%0d", errors);
  endtask

  task automatic test_debug_halt;
    instruction = rtype(5'd1, 5'd2, 5'd7, ADD);
    tick;
    checks++; if (rd !== 5'd7 || o_valid !== 1'b1) begin errors++; $display("FAIL dbg_pre: got rd=%0d valid=%b expected 7 1", rd, o_valid); end
    debug_halt = 1'b1; instruction = rtype(5'd1, 5'd0, 5'd0, 6'h08);
    wb_write = 1'b1; wb_addr = 5'd9; wb_data = 32'h99; #1;
    checks++; if (stall !== 1'b1 || jump !== 1'b0) begin errors++; $display("FAIL dbg_stall: got stall=%b jump=%b expected 1 0", stall, jump); end
    tick;
    checks++; if (rd !== 5'd7 || o_valid !== 1'b1) begin errors++; $display("FAIL dbg_hold: got rd=%0d valid=%b expected 7 1", rd, o_valid); end
    wb_write = 1'b0; debug_halt = 1'b0; valid = 1'b0; dbg_addr = 5'd9; #1;
    checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL dbg_wb_block: got %h expected 0", dbg_data); end
    $display("test_debug_halt done: errors=%0d", errors);
  endtask

  task automatic test_halt;
    valid = 1'b1; instruction = 32'hFFFF_FFFF; flush = 1'b1;
    tick;
    flush = 1'b0; valid = 1'b0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL halt_flushed: got stall=%b expected 0", stall); end
    valid = 1'b1;
    tick;
    valid = 1'b0; #1;
    checks++; if (stall !== 1'b1 || o_valid !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL drain_c1: got stall=%b valid=%b halted=%b expected 1 0 0", stall, o_valid, halted); end
    for (int i = 2; i <= 3; i++) begin
      tick;
      checks++; if (halted !== 1'b0 || o_valid !== 1'b0) begin errors++; $display("FAIL drain_c%0d: got halted=%b valid=%b expected 0 0", i, halted, o_valid); end
    end
    tick;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halted_rise: got %b expected 1", halted); end
    valid = 1'b1; instruction = rtype(5'd1, 5'd0, 5'd0, 6'h08);
    tick; tick;
    checks++; if (halted !== 1'b1 || jump !== 1'b0 || stall !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL halted_sticky: got halted=%b jump=%b stall=%b valid=%b expected 1 0 1 0", halted, jump, stall, o_valid); end
    reset = 1'b1; valid = 1'b0;
    tick;
    reset = 1'b0; #1;
    checks++; if (halted !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL halt_reset: got halted=%b stall=%b expected 0 0", halted, stall); end
    valid = 1'b1; instruction = rtype(5'd0, 5'd0, 5'd8, ADD);
    tick;
    checks++; if (o_valid !== 1'b1 || rd !== 5'd8) begin errors++; $display("FAIL run_after_reset: got valid=%b rd=%0d expected 1 8", o_valid, rd); end
    $display("test_halt done: errors=%0d", errors);
  endtask

  initial begin
    test_reset;
    test_regfile_add;
    test_bypass;
    test_hazard;
    test_branch;
    test_jal;
    test_mem;
    test_debug_halt;
    test_halt;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
